i2cmb_byte_engine: RTL

I2CMB_BYTE_ENGINE -- requirements
Module: i2cmb_byte_engine

---
 rtl/i2cmb_byte_engine.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/i2cmb_byte_engine.sv
// Byte-level I2C master engine: START/STOP/WRITE/READ and bus select over up to 16 buses.
// Each bit is four CLK_DIV-cycle phases; released-SCL phases stall while a slave stretches.
module i2cmb_byte_engine #(
  parameter int CLK_DIV   = 250,
  parameter int NUM_BUSES = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [2:0]           cmd_code_i,
  input  logic [7:0]           cmd_data_i,
  output logic                 rsp_valid_o,
  output logic [1:0]           rsp_code_o,
  output logic [7:0]           rsp_data_o,
  output logic [3:0]           bus_id_o,
  output logic                 busy_o,
  output logic [NUM_BUSES-1:0] scl_o,
  output logic [NUM_BUSES-1:0] sda_o,
  input  logic [NUM_BUSES-1:0] scl_i,
  input  logic [NUM_BUSES-1:0] sda_i
);

  localparam logic [2:0] OP_WRITE    = 3'b001;
  localparam logic [2:0] OP_READ_ACK = 3'b010;
  localparam logic [2:0] OP_READ_NAK = 3'b011;
  localparam logic [2:0] OP_START    = 3'b100;
  localparam logic [2:0] OP_STOP     = 3'b101;
  localparam logic [2:0] OP_SET_BUS  = 3'b110;

  localparam logic [1:0] RSP_DONE = 2'd0;
  localparam logic [1:0] RSP_NAK  = 2'd1;
  localparam logic [1:0] RSP_ARB  = 2'd2;
  localparam logic [1:0] RSP_ERR  = 2'd3;

  localparam logic [9:0] LAST = 10'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_STOP, S_WRBIT, S_RDBIT, S_ACKBIT, S_RESP
  } state_t;

  state_t     state;
  logic [1:0] ph;
  logic [9:0] cnt;
  logic [2:0] bitn;
  logic [7:0] sh;
  logic [7:0] rd_byte;
  logic       rd_op, ack_lvl, ack_smp, rsp_rd;
  logic       scl_drv, sda_drv;
  logic       scl_in, sda_in, stall, xmit, arb_lost;

  assign scl_in = scl_i[bus_id_o];
  assign sda_in = sda_i[bus_id_o];
  assign stall  = scl_drv & ~scl_in;

  // Arbitration only applies where this master is the one sending bits.
  assign xmit     = (state == S_START) | (state == S_STOP) | (state == S_WRBIT) |
                    ((state == S_ACKBIT) & rd_op);
  assign arb_lost = xmit & sda_drv & scl_drv & scl_in & ~sda_in;

  assign cmd_ready_o = (state == S_IDLE) & ~rst_i;
  assign rsp_data_o  = (rsp_valid_o & ~rsp_rd) ? 8'h00 : rd_byte;

  for (genvar g = 0; g < NUM_BUSES; g++) begin : g_bus
    assign scl_o[g] = (bus_id_o == 4'(g)) ? scl_drv : 1'b1;
    assign sda_o[g] = (bus_id_o == 4'(g)) ? sda_drv : 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      ph          <= '0;
      cnt         <= '0;
      bitn        <= '0;
      sh          <= '0;
      rd_byte     <= '0;
      rd_op       <= 1'b0;
      ack_lvl     <= 1'b1;
      ack_smp     <= 1'b0;
      rsp_rd      <= 1'b0;
      scl_drv     <= 1'b1;
      sda_drv     <= 1'b1;
      busy_o      <= 1'b0;
      bus_id_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_code_o  <= RSP_DONE;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid_i) begin
          cnt         <= '0;
          ph          <= '0;
          bitn        <= '0;
          sh          <= cmd_data_i;
          rsp_rd      <= 1'b0;
          // Immediate ERR unless a legal command below takes over.
          state       <= S_RESP;
          rsp_valid_o <= 1'b1;
          rsp_code_o  <= RSP_ERR;
          case (cmd_code_i)
            OP_START: begin
              state <= S_START; rsp_valid_o <= 1'b0; sda_drv <= 1'b1;
            end
            OP_STOP: begin
              state <= S_STOP; rsp_valid_o <= 1'b0; sda_drv <= 1'b0;
            end
            OP_WRITE: if (busy_o) begin
              state <= S_WRBIT; rsp_valid_o <= 1'b0; sda_drv <= cmd_data_i[7]; rd_op <= 1'b0;
            end
            OP_READ_ACK, OP_READ_NAK: if (busy_o) begin
              state <= S_RDBIT; rsp_valid_o <= 1'b0; sda_drv <= 1'b1; rd_op <= 1'b1;
              ack_lvl <= (cmd_code_i == OP_READ_NAK);
            end
            OP_SET_BUS: if (!busy_o && int'(cmd_data_i) < NUM_BUSES) begin
              bus_id_o   <= cmd_data_i[3:0];
              rsp_code_o <= RSP_DONE;
            end
            default: ;
          endcase
        end
        S_RESP: begin
          rsp_valid_o <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          if (arb_lost) begin
            scl_drv     <= 1'b1;
            sda_drv     <= 1'b1;
            busy_o      <= 1'b0;
            rsp_rd      <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_code_o  <= RSP_ARB;
            state       <= S_RESP;
          end else if (stall) begin
            cnt <= cnt;
          end else if (cnt != LAST) begin
            cnt <= cnt + 10'd1;
          end else begin
            cnt <= '0;
            ph  <= ph + 2'd1;
            // Drive levels for the phase being entered; phase 3 ending closes the symbol.
            case (state)
              S_START: case (ph)
                2'd0: scl_drv <= 1'b1;
                2'd1: sda_drv <= 1'b0;
                2'd2: scl_drv <= 1'b0;
                default: begin
                  busy_o <= 1'b1; state <= S_RESP; rsp_valid_o <= 1'b1; rsp_code_o <= RSP_DONE;
                end
              endcase
              S_STOP: case (ph)
                2'd0: scl_drv <= 1'b1;
                2'd1: sda_drv <= 1'b1;
                2'd2: ;
                default: begin
                  busy_o <= 1'b0; state <= S_RESP; rsp_valid_o <= 1'b1; rsp_code_o <= RSP_DONE;
                end
              endcase
              S_WRBIT, S_RDBIT: case (ph)
                2'd0: scl_drv <= 1'b1;
                2'd1: sh <= {sh[6:0], sda_in};
                2'd2: scl_drv <= 1'b0;
                default: begin
                  if (bitn == 3'd7) begin
                    state   <= S_ACKBIT;
                    sda_drv <= rd_op ? ack_lvl : 1'b1;
                  end else begin
                    bitn    <= bitn + 3'd1;
                    sda_drv <= rd_op | sh[7];
                  end
                end
              endcase
              S_ACKBIT: case (ph)
                2'd0: scl_drv <= 1'b1;
                2'd1: ack_smp <= sda_in;
                2'd2: scl_drv <= 1'b0;
                default: begin
                  state       <= S_RESP;
                  rsp_valid_o <= 1'b1;
                  rsp_code_o  <= (!rd_op && ack_smp) ? RSP_NAK : RSP_DONE;
                  rsp_rd      <= rd_op;
                  if (rd_op) rd_byte <= sh;
                end
              endcase
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule
